// File: rtl/traffic_phase_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : traffic_phase_scheduler
//  Purpose  : Round-robin phase controller for a two-road intersection with
//             one pedestrian crossing. The all-red conflict zone is shared
//             between road A, road B and the pedestrian walk phase.
//  Ports    : clk, reset (async, active-high)
//             req_a, req_b   - cleaned level vehicle requests
//             ped_req        - cleaned pedestrian button (rising edge used)
//             light_a/b      - {red, yellow, green}, one-hot
//             walk           - pedestrian walk indication
//             timer          - seconds in the current state (saturates at 15)
//             state          - current state encoding
//             pending        - latched requests {ped, b, a}
//  Revision : 1.0 - initial release
// ============================================================================
module traffic_phase_scheduler #(
    parameter int TICK_DIV  = 100_000_000,
    parameter int MIN_GREEN = 6,
    parameter int MAX_GREEN = 9,
    parameter int YELLOW    = 2,
    parameter int ALL_RED   = 2,
    parameter int PED_WALK  = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_a,
    input  logic       req_b,
    input  logic       ped_req,
    output logic [2:0] light_a,
    output logic [2:0] light_b,
    output logic       walk,
    output logic [3:0] timer,
    output logic [3:0] state,
    output logic [2:0] pending
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int              c_PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_PW-1:0] c_TICK_LAST = c_PW'(TICK_DIV - 1);

    localparam logic [3:0] c_MIN_GREEN = 4'(MIN_GREEN);
    localparam logic [3:0] c_MAX_GREEN = 4'(MAX_GREEN);
    localparam logic [3:0] c_YELLOW    = 4'(YELLOW);
    localparam logic [3:0] c_ALL_RED   = 4'(ALL_RED);
    localparam logic [3:0] c_PED_WALK  = 4'(PED_WALK);
    localparam logic [3:0] c_TIMER_MAX = 4'd15;

    localparam logic [3:0] c_S_INIT     = 4'd0;
    localparam logic [3:0] c_S_GREEN_A  = 4'd1;
    localparam logic [3:0] c_S_YELLOW_A = 4'd2;
    localparam logic [3:0] c_S_RED_A    = 4'd3;
    localparam logic [3:0] c_S_GREEN_B  = 4'd4;
    localparam logic [3:0] c_S_YELLOW_B = 4'd5;
    localparam logic [3:0] c_S_RED_B    = 4'd6;
    localparam logic [3:0] c_S_WALK     = 4'd7;
    localparam logic [3:0] c_S_WALK_CLR = 4'd8;

    // Identity of the requester most recently granted the conflict zone
    localparam logic [1:0] c_SRV_A = 2'd0;
    localparam logic [1:0] c_SRV_B = 2'd1;
    localparam logic [1:0] c_SRV_P = 2'd2;

    localparam logic [2:0] c_LIGHT_RED    = 3'b100;
    localparam logic [2:0] c_LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] c_LIGHT_GREEN  = 3'b001;

    // ------------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------------
    logic [c_PW-1:0] r_presc;
    logic [3:0]      r_state;
    logic [3:0]      r_timer;
    logic            r_pend_a;
    logic            r_pend_b;
    logic            r_pend_p;
    logic [1:0]      r_last;
    logic            r_ped_d;

    logic            w_tick;
    logic [3:0]      w_state_nxt;
    logic [3:0]      w_arb_state;
    logic            w_ped_rise;
    logic            w_enter_a;
    logic            w_enter_b;
    logic            w_enter_p;
    logic            w_conf_a;
    logic            w_conf_b;

    // ------------------------------------------------------------------------
    // One-second tick prescaler
    // ------------------------------------------------------------------------
    assign w_tick = (r_presc == c_TICK_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + c_PW'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Round-robin arbitration: scan the ring A -> B -> P starting just after
    // the last served requester. With nothing pending, road A rests in green.
    // ------------------------------------------------------------------------
    always_comb begin
        w_arb_state = c_S_GREEN_A;
        case (r_last)
            c_SRV_A: begin
                if (r_pend_b)      w_arb_state = c_S_GREEN_B;
                else if (r_pend_p) w_arb_state = c_S_WALK;
                else if (r_pend_a) w_arb_state = c_S_GREEN_A;
            end
            c_SRV_B: begin
                if (r_pend_p)      w_arb_state = c_S_WALK;
                else if (r_pend_a) w_arb_state = c_S_GREEN_A;
                else if (r_pend_b) w_arb_state = c_S_GREEN_B;
            end
            default: begin
                if (r_pend_a)      w_arb_state = c_S_GREEN_A;
                else if (r_pend_b) w_arb_state = c_S_GREEN_B;
                else if (r_pend_p) w_arb_state = c_S_WALK;
            end
        endcase
    end

    // A green phase only yields when someone else is waiting
    assign w_conf_a = r_pend_b | r_pend_p;
    assign w_conf_b = r_pend_a | r_pend_p;

    // ------------------------------------------------------------------------
    // Phase FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_S_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Phase FSM: next-state logic. Legal transitions are tick-qualified;
    // an illegal encoding recovers to INIT immediately.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_INIT, c_S_RED_A, c_S_RED_B, c_S_WALK_CLR: begin
                if (w_tick && (r_timer >= c_ALL_RED)) w_state_nxt = w_arb_state;
            end
            c_S_GREEN_A: begin
                // Max-out while conflicted, or gap-out once own demand is gone
                if (w_tick && w_conf_a &&
                    ((r_timer >= c_MAX_GREEN) || (!req_a && (r_timer >= c_MIN_GREEN))))
                    w_state_nxt = c_S_YELLOW_A;
            end
            c_S_GREEN_B: begin
                if (w_tick && w_conf_b &&
                    ((r_timer >= c_MAX_GREEN) || (!req_b && (r_timer >= c_MIN_GREEN))))
                    w_state_nxt = c_S_YELLOW_B;
            end
            c_S_YELLOW_A: begin
                if (w_tick && (r_timer >= c_YELLOW)) w_state_nxt = c_S_RED_A;
            end
            c_S_YELLOW_B: begin
                if (w_tick && (r_timer >= c_YELLOW)) w_state_nxt = c_S_RED_B;
            end
            c_S_WALK: begin
                if (w_tick && (r_timer >= c_PED_WALK)) w_state_nxt = c_S_WALK_CLR;
            end
            default: begin
                w_state_nxt = c_S_INIT;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State timer: restarts at 1 on every state change, counts ticks otherwise
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timer <= 4'd1;
        end else if (w_state_nxt != r_state) begin
            r_timer <= 4'd1;
        end else if (w_tick && (r_timer != c_TIMER_MAX)) begin
            r_timer <= r_timer + 4'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Request latching. Grant entry clears a flag and takes priority over a
    // simultaneous set.
    // ------------------------------------------------------------------------
    assign w_ped_rise = ped_req & ~r_ped_d;
    assign w_enter_a  = (w_state_nxt == c_S_GREEN_A) && (r_state != c_S_GREEN_A);
    assign w_enter_b  = (w_state_nxt == c_S_GREEN_B) && (r_state != c_S_GREEN_B);
    assign w_enter_p  = (w_state_nxt == c_S_WALK)    && (r_state != c_S_WALK);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend_a <= 1'b0;
            r_pend_b <= 1'b0;
            r_pend_p <= 1'b0;
            r_ped_d  <= 1'b0;
        end else begin
            r_ped_d <= ped_req;

            if (w_enter_a)                             r_pend_a <= 1'b0;
            else if (req_a && (r_state != c_S_GREEN_A)) r_pend_a <= 1'b1;

            if (w_enter_b)                             r_pend_b <= 1'b0;
            else if (req_b && (r_state != c_S_GREEN_B)) r_pend_b <= 1'b1;

            if (w_enter_p)                                r_pend_p <= 1'b0;
            else if (w_ped_rise && (r_state != c_S_WALK)) r_pend_p <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Last served requester, updated on grant entry
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last <= c_SRV_P;
        end else if (w_enter_a) begin
            r_last <= c_SRV_A;
        end else if (w_enter_b) begin
            r_last <= c_SRV_B;
        end else if (w_enter_p) begin
            r_last <= c_SRV_P;
        end
    end

    // ------------------------------------------------------------------------
    // Moore output decode
    // ------------------------------------------------------------------------
    always_comb begin
        light_a = c_LIGHT_RED;
        light_b = c_LIGHT_RED;
        walk    = 1'b0;
        case (r_state)
            c_S_GREEN_A:  light_a = c_LIGHT_GREEN;
            c_S_YELLOW_A: light_a = c_LIGHT_YELLOW;
            c_S_GREEN_B:  light_b = c_LIGHT_GREEN;
            c_S_YELLOW_B: light_b = c_LIGHT_YELLOW;
            c_S_WALK:     walk    = 1'b1;
            default: ;
        endcase
    end

    assign timer   = r_timer;
    assign state   = r_state;
    assign pending = {r_pend_p, r_pend_b, r_pend_a};

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_traffic_phase_scheduler
//  Purpose  : Self-checking bench for traffic_phase_scheduler. Directed
//             scenarios followed by a random-request run, all compared
//             against a rule-level reference model every clock.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_phase_scheduler;

    localparam int TD        = 4;
    localparam int MIN_GREEN = 6;
    localparam int MAX_GREEN = 9;
    localparam int YELLOW    = 2;
    localparam int ALL_RED   = 2;
    localparam int PED_WALK  = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_a;
    logic       req_b;
    logic       ped_req;
    logic [2:0] light_a;
    logic [2:0] light_b;
    logic       walk;
    logic [3:0] timer;
    logic [3:0] state;
    logic [2:0] pending;

    int checks = 0;
    int errors = 0;

    // Reference model: requesters indexed 0=A, 1=B, 2=P
    int m_presc;
    int m_state;
    int m_timer;
    int m_last;
    bit m_ped_prev;
    bit m_pend [3];
    int grant_of [3] = '{1, 4, 7};

    traffic_phase_scheduler #(
        .TICK_DIV  (TD),
        .MIN_GREEN (MIN_GREEN),
        .MAX_GREEN (MAX_GREEN),
        .YELLOW    (YELLOW),
        .ALL_RED   (ALL_RED),
        .PED_WALK  (PED_WALK)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req_a   (req_a),
        .req_b   (req_b),
        .ped_req (ped_req),
        .light_a (light_a),
        .light_b (light_b),
        .walk    (walk),
        .timer   (timer),
        .state   (state),
        .pending (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_presc    = 0;
        m_state    = 0;
        m_timer    = 1;
        m_last     = 2;
        m_ped_prev = 1'b0;
        for (int r = 0; r < 3; r++) m_pend[r] = 1'b0;
    endtask

    function automatic int arbitrate();
        for (int k = 1; k <= 3; k++) begin
            if (m_pend[(m_last + k) % 3]) return grant_of[(m_last + k) % 3];
        end
        return 1;
    endfunction

    // Advance the model by one clock edge using the inputs seen at that edge
    task automatic model_edge();
        bit tick;
        bit rise;
        bit conflict;
        bit own;
        bit set_r [3];
        int me;
        int ns;
        tick = (m_presc == TD - 1);
        rise = ped_req && !m_ped_prev;
        ns   = m_state;
        if (tick) begin
            case (m_state)
                1, 4: begin
                    me       = (m_state == 1) ? 0 : 1;
                    conflict = m_pend[1 - me] | m_pend[2];
                    own      = (me == 0) ? req_a : req_b;
                    if (conflict && (m_timer >= MAX_GREEN || (!own && m_timer >= MIN_GREEN)))
                        ns = m_state + 1;
                end
                2, 5:    if (m_timer >= YELLOW)   ns = m_state + 1;
                7:       if (m_timer >= PED_WALK) ns = 8;
                default: if (m_timer >= ALL_RED)  ns = arbitrate();
            endcase
        end
        set_r[0] = req_a && (m_state != 1);
        set_r[1] = req_b && (m_state != 4);
        set_r[2] = rise  && (m_state != 7);
        for (int r = 0; r < 3; r++) begin
            if (ns == grant_of[r] && m_state != grant_of[r]) begin
                m_pend[r] = 1'b0;
                m_last    = r;
            end else if (set_r[r]) begin
                m_pend[r] = 1'b1;
            end
        end
        if (ns != m_state)               m_timer = 1;
        else if (tick && m_timer < 15)   m_timer = m_timer + 1;
        m_state    = ns;
        m_presc    = (m_presc + 1) % TD;
        m_ped_prev = ped_req;
    endtask

    task automatic check_all();
        logic [2:0] ea;
        logic [2:0] eb;
        int         active;
        ea = (m_state == 1) ? 3'b001 : (m_state == 2) ? 3'b010 : 3'b100;
        eb = (m_state == 4) ? 3'b001 : (m_state == 5) ? 3'b010 : 3'b100;
        chk("state",   32'(state),   32'(m_state));
        chk("timer",   32'(timer),   32'(m_timer));
        chk("light_a", 32'(light_a), 32'(ea));
        chk("light_b", 32'(light_b), 32'(eb));
        chk("walk",    32'(walk),    32'(m_state == 7));
        chk("pending", 32'(pending), 32'({m_pend[2], m_pend[1], m_pend[0]}));
        active = int'(light_a[0] | light_a[1]) + int'(light_b[0] | light_b[1]) + int'(walk);
        chk("conflict_safety", 32'(active <= 1), 32'd1);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    // Step until the DUT reaches target; n = steps taken, last_timer = timer
    // value in the cycle that produced the transition
    task automatic run_until(input logic [3:0] target, input int bound,
                             output int n, output int last_timer);
        n          = 0;
        last_timer = -1;
        while (state !== target && n < bound) begin
            last_timer = int'(timer);
            step();
            n++;
        end
        checks++;
        assert (state === target) else begin
            errors++;
            $error("FAIL timeout_state observed=%0d expected=%0d", state, target);
        end
    endtask

    // Assert reset between edges, verify asynchronous effect, then release
    task automatic apply_reset(input string tag);
        #3;
        reset = 1'b1;
        #1;
        chk({tag, "_state"},   32'(state),   32'd0);
        chk({tag, "_timer"},   32'(timer),   32'd1);
        chk({tag, "_light_a"}, 32'(light_a), 32'b100);
        chk({tag, "_light_b"}, 32'(light_b), 32'b100);
        chk({tag, "_walk"},    32'(walk),    32'd0);
        chk({tag, "_pending"}, 32'(pending), 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #4;
        reset = 1'b0;
    endtask

    initial begin
        int n;
        int lt;
        int walk_steps;
        reset   = 1'b1;
        req_a   = 1'b0;
        req_b   = 1'b0;
        ped_req = 1'b0;
        model_reset();
        #2;
        chk("por_state",   32'(state),   32'd0);
        chk("por_timer",   32'(timer),   32'd1);
        chk("por_light_a", 32'(light_a), 32'b100);
        chk("por_light_b", 32'(light_b), 32'b100);
        #6;
        reset = 1'b0;

        // 1: INIT for 8 cycles, then GREEN_A resting, timer saturates
        repeat (7) step();
        chk("t1_init_hold", 32'(state), 32'd0);
        step();
        chk("t1_green_a", 32'(state), 32'd1);
        repeat (64) step();
        chk("t1_rest_state", 32'(state), 32'd1);
        chk("t1_timer_sat",  32'(timer), 32'd15);

        // 2: req_b pulse at timer=2, gap-out at timer=6
        apply_reset("t2_rst");
        repeat (8) step();
        n = 0;
        while (timer !== 4'd2 && n < 16) begin step(); n++; end
        chk("t2_timer2", 32'(timer), 32'd2);
        req_b = 1'b1;
        step();
        req_b = 1'b0;
        run_until(4'd2, 200, n, lt);
        chk("t2_gapout_timer", 32'(lt), 32'd6);
        chk("t2_pending_b_set", 32'(pending), 32'b010);
        run_until(4'd3, 50, n, lt);
        chk("t2_yellow_cycles", 32'(n), 32'd8);
        run_until(4'd4, 50, n, lt);
        chk("t2_red_cycles", 32'(n), 32'd8);
        chk("t2_pending_b_clr", 32'(pending[1]), 32'd0);

        // 4: GREEN_B with pending_a and a pedestrian edge -> WALK
        req_a   = 1'b1;
        ped_req = 1'b1;
        step();
        req_a = 1'b0;
        step();
        ped_req = 1'b0;
        chk("t4_pending", 32'(pending), 32'b101);
        run_until(4'd5, 200, n, lt);
        chk("t4_gapout_timer", 32'(lt), 32'd6);
        run_until(4'd6, 50, n, lt);
        run_until(4'd7, 50, n, lt);
        chk("t4_walk_on", 32'(walk), 32'd1);
        chk("t4_pending_walk", 32'(pending), 32'b001);
        repeat (2) step();
        ped_req = 1'b1;
        step();
        chk("t4_ped_in_walk_a", 32'(pending[2]), 32'd0);
        step();
        chk("t4_ped_in_walk_b", 32'(pending[2]), 32'd0);
        walk_steps = 4;
        req_a = 1'b1;
        run_until(4'd8, 50, n, lt);
        chk("t4_walk_cycles", 32'(n + walk_steps), 32'd20);
        run_until(4'd1, 50, n, lt);
        chk("t4_clr_cycles", 32'(n), 32'd8);

        // 6: req_a held through GREEN_A entry leaves pending_a clear
        chk("t6_pending_a_entry", 32'(pending[0]), 32'd0);
        step();
        ped_req = 1'b0;
        chk("t6_pending_a_next", 32'(pending[0]), 32'd0);

        // 3: req_a held, req_b pending -> max-out at timer 9
        req_b = 1'b1;
        step();
        req_b = 1'b0;
        run_until(4'd2, 200, n, lt);
        chk("t3_maxout_timer", 32'(lt), 32'd9);

        // 5: into YELLOW_B, then asynchronous reset between edges
        run_until(4'd4, 100, n, lt);
        req_a = 1'b1;
        run_until(4'd5, 200, n, lt);
        step();
        chk("t5_in_yellow_b", 32'(state), 32'd5);
        apply_reset("t5_rst");
        req_a = 1'b0;

        // 7: random request run with full per-cycle comparison
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(7) == 0)  req_a   = ~req_a;
            if ($urandom_range(7) == 0)  req_b   = ~req_b;
            if ($urandom_range(5) == 0)  ped_req = ~ped_req;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
